// File: rtl/axis_pkt_pkg.sv
// rtl/axis_pkt_pkg.sv - shared state type and length/keep helpers for the AXIS packet source
package axis_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } pkt_state_e;

    // Widest keep vector the helpers produce (DATAW up to 1024 bits).
    localparam int MAX_KEEPW = 128;

    function automatic logic [MAX_KEEPW-1:0] keep_from_rem(input int unsigned rem,
                                                           input int unsigned keepw);
        logic [MAX_KEEPW-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < MAX_KEEPW; i++) begin
            if ((rem == 0 && i < keepw) || i < rem) begin
                k[i] = 1'b1;
            end
        end
        return k;
    endfunction

    function automatic int unsigned beats_from_len(input int unsigned len,
                                                   input int unsigned keepw);
        return (len + keepw - 1) / keepw;
    endfunction

endpackage

// File: rtl/axis_pkt_src_beat_pack.sv
// rtl/axis_pkt_src_beat_pack.sv - picks one beat of bytes from a byte array, zeroing lanes past count
module axis_beat_pack #(
    parameter int KEEPW = 8,
    parameter int DTMP  = 4096,
    parameter int BIDXW = 10,
    parameter int CW    = 4
) (
    input  logic [7:0]         mem [0:DTMP-1],
    input  logic [BIDXW-1:0]   beat,
    input  logic [CW-1:0]      count,
    output logic [KEEPW*8-1:0] tdata
);

    localparam int AW = (DTMP > 1) ? $clog2(DTMP) : 1;

    logic [31:0] idx;

    always_comb begin
        tdata = '0;
        idx   = '0;
        for (int k = 0; k < KEEPW; k++) begin
            idx = 32'(beat) * KEEPW + 32'(k);
            if (32'(k) < 32'(count) && idx < 32'(DTMP)) begin
                tdata[k*8 +: 8] = mem[idx[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/axis_pkt_src.sv
// rtl/axis_pkt_src.sv - byte-array packet to AXIS streamer with backpressure; AXIS_PKT_SRC_GAP_EN adds inter-beat gaps
module axis_pkt_src
    import axis_pkt_pkg::*;
#(
    parameter  int DATAW = 64,
    localparam int KEEPW = DATAW / 8,
    parameter  int DTMP  = 4096,
    parameter  int LENW  = $clog2(DTMP + 1)
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESET,
    input  logic             i_req,
    input  logic [7:0]       i_data [0:DTMP-1],
    input  logic [LENW-1:0]  i_len,
`ifdef AXIS_PKT_SRC_GAP_EN
    input  logic [7:0]       i_gap,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [DATAW-1:0] m_axis_tdata,
    output logic [KEEPW-1:0] m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    localparam int NBMAX = (DTMP + KEEPW - 1) / KEEPW;
    localparam int BIDXW = $clog2(NBMAX + 1);
    localparam int CW    = $clog2(KEEPW + 1);

    pkt_state_e state_q, state_d;

    logic [7:0]       pkt_mem [0:DTMP-1];
    logic [BIDXW-1:0] beat_q, beat_d, last_q, last_d, beat_nx;
    logic [CW-1:0]    lcnt_q, lcnt_d;
    logic [KEEPW-1:0] lkeep_q, lkeep_d;
`ifdef AXIS_PKT_SRC_GAP_EN
    logic [7:0]       gap_len_q, gap_len_d, gap_cnt_q, gap_cnt_d;
`endif

    logic [DATAW-1:0] tdata_d;
    logic [KEEPW-1:0] tkeep_d;
    logic             tlast_d, tvalid_d, done_d, err_d, load, advance, nx_last;

    logic                 req_ok;
    logic [31:0]          req_nb, req_rem;
    logic [BIDXW-1:0]     req_last;
    logic [CW-1:0]        req_cnt, first_cnt;
    logic [MAX_KEEPW-1:0] keep_full;
    logic [KEEPW-1:0]     req_keep;
    logic [DATAW-1:0]     first_data, next_data;

    // Request decode: beat count, last-beat byte count and last-beat keep.
    always_comb begin
        req_ok    = (i_len != '0) && (32'(i_len) <= 32'(DTMP));
        req_nb    = beats_from_len(32'(i_len), KEEPW);
        req_rem   = 32'(i_len) % 32'(KEEPW);
        req_last  = BIDXW'(req_nb - 32'd1);
        req_cnt   = (req_rem == 32'd0) ? CW'(KEEPW) : CW'(req_rem);
        keep_full = keep_from_rem(req_rem, KEEPW);
        req_keep  = keep_full[KEEPW-1:0];
        first_cnt = (req_nb == 32'd1) ? req_cnt : CW'(KEEPW);
    end

    assign beat_nx = beat_q + 1'b1;
    assign nx_last = (beat_nx == last_q);

    // Beat 0 comes straight from the request bytes since the buffer loads on the same edge.
    axis_beat_pack #(.KEEPW(KEEPW), .DTMP(DTMP), .BIDXW(BIDXW), .CW(CW)) u_pack_first (
        .mem   (i_data),
        .beat  ('0),
        .count (first_cnt),
        .tdata (first_data)
    );

    axis_beat_pack #(.KEEPW(KEEPW), .DTMP(DTMP), .BIDXW(BIDXW), .CW(CW)) u_pack_next (
        .mem   (pkt_mem),
        .beat  (beat_nx),
        .count (nx_last ? lcnt_q : CW'(KEEPW)),
        .tdata (next_data)
    );

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        last_d   = last_q;
        lcnt_d   = lcnt_q;
        lkeep_d  = lkeep_q;
        tdata_d  = m_axis_tdata;
        tkeep_d  = m_axis_tkeep;
        tlast_d  = m_axis_tlast;
        tvalid_d = m_axis_tvalid;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
`ifdef AXIS_PKT_SRC_GAP_EN
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    if (req_ok) begin
                        load     = 1'b1;
                        state_d  = SEND;
                        beat_d   = '0;
                        last_d   = req_last;
                        lcnt_d   = req_cnt;
                        lkeep_d  = req_keep;
                        tdata_d  = first_data;
                        tkeep_d  = (req_nb == 32'd1) ? req_keep : '1;
                        tlast_d  = (req_nb == 32'd1);
                        tvalid_d = 1'b1;
`ifdef AXIS_PKT_SRC_GAP_EN
                        gap_len_d = i_gap;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    if (m_axis_tlast) begin
                        state_d  = DONE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        done_d   = 1'b1;
                    end
`ifdef AXIS_PKT_SRC_GAP_EN
                    else if (gap_len_q != 8'd0) begin
                        state_d   = GAP;
                        tvalid_d  = 1'b0;
                        gap_cnt_d = gap_len_q;
                    end
`endif
                    else begin
                        advance = 1'b1;
                    end
                end
            end
`ifdef AXIS_PKT_SRC_GAP_EN
            GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q == 8'd1) begin
                    advance = 1'b1;
                end
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            state_d  = SEND;
            beat_d   = beat_nx;
            tdata_d  = next_data;
            tkeep_d  = nx_last ? lkeep_q : '1;
            tlast_d  = nx_last;
            tvalid_d = 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            last_q        <= '0;
            lcnt_q        <= '0;
            lkeep_q       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
`ifdef AXIS_PKT_SRC_GAP_EN
            gap_len_q     <= '0;
            gap_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            last_q        <= last_d;
            lcnt_q        <= lcnt_d;
            lkeep_q       <= lkeep_d;
            m_axis_tdata  <= tdata_d;
            m_axis_tkeep  <= tkeep_d;
            m_axis_tlast  <= tlast_d;
            m_axis_tvalid <= tvalid_d;
            o_busy        <= (state_d != IDLE);
            o_done        <= done_d;
            o_err         <= err_d;
`ifdef AXIS_PKT_SRC_GAP_EN
            gap_len_q     <= gap_len_d;
            gap_cnt_q     <= gap_cnt_d;
`endif
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (load) begin
            pkt_mem <= i_data;
        end
    end

endmodule
